// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if -- instruction-memory fetch bus between the IF stage and imem.
//
// Signals:
//   imem_req    fetch request (driven by the fetch stage)
//   imem_addr   fetch address, held stable while a request waits on ready
//   imem_ready  imem_rdata is valid for imem_addr this cycle
//   imem_rdata  fetched instruction word
//
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface if_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage: PC register, imem request handshake,
// one-entry skid buffer and the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_pc_write          hazard unit PCWrite   (0 = stall)
//   i_ifid_write        hazard unit IFIDWrite (0 = stall)
//   i_ifid_flush        clear IF/ID to a bubble
//   i_redirect_valid    branch/jump taken, target on i_redirect_pc
//   imem                if_stage_if.master fetch bus
//   o_ifid_pc/_pc4      PC and PC+4 of the instruction in IF/ID
//   o_ifid_instr        instruction (0 = NOP when bubble)
//   o_ifid_valid        IF/ID holds a real instruction
//   o_fetch_busy        request outstanding without data, or draining
//
// Optional feature (macro IF_PERF_CNT_EN): adds o_perf_fetch_cnt and
// o_perf_stall_cnt, free-running 32-bit counters.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pc_write,
  input  logic              i_ifid_write,
  input  logic              i_ifid_flush,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  if_stage_if.master        imem,
  output logic [ADDR_W-1:0] o_ifid_pc,
  output logic [ADDR_W-1:0] o_ifid_pc4,
  output logic [DATA_W-1:0] o_ifid_instr,
  output logic              o_ifid_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       o_perf_fetch_cnt,
  output logic [31:0]       o_perf_stall_cnt,
`endif
  output logic              o_fetch_busy
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN, S_HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_redir_buf;   // redirect target remembered while draining
  logic [DATA_W-1:0] r_skid;        // instruction captured when a stall hit a ready cycle
  logic              r_imem_req;

  logic              w_stall;
  logic              w_load;        // a real instruction enters IF/ID this edge
  logic [DATA_W-1:0] w_load_instr;
  logic [ADDR_W-1:0] w_pc4;

  assign w_stall        = !i_pc_write || !i_ifid_write;
  assign w_pc4          = r_pc + ADDR_W'(4);   // wraps modulo 2^ADDR_W
  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_pc;
  assign o_fetch_busy   = (r_state == S_DRAIN) ||
                          (r_state == S_FETCH && r_imem_req && !imem.imem_ready);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_load       = 1'b0;
    w_load_instr = r_skid;
    unique case (r_state)
      S_FETCH: if (imem.imem_ready && !i_redirect_valid && !w_stall) begin
        w_load       = 1'b1;
        w_load_instr = imem.imem_rdata;
      end
      S_HOLD:  w_load = !i_redirect_valid && !w_stall;
      default: ;
    endcase
  end

  // Fetch FSM: PC, skid buffer, redirect buffer and the registered request.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_redir_buf <= '0;
      r_skid      <= '0;
      r_imem_req  <= 1'b0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem.imem_ready) begin
            if (i_redirect_valid) begin
              r_pc <= i_redirect_pc;               // rdata discarded
            end else if (w_stall) begin
              r_skid     <= imem.imem_rdata;
              r_state    <= S_HOLD;
              r_imem_req <= 1'b0;
            end else begin
              r_pc <= w_pc4;
            end
          end else if (i_redirect_valid) begin
            // Address must stay put until the pending access completes.
            r_redir_buf <= i_redirect_pc;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem.imem_ready) begin
            r_pc    <= i_redirect_valid ? i_redirect_pc : r_redir_buf;
            r_state <= S_FETCH;
          end else if (i_redirect_valid) begin
            r_redir_buf <= i_redirect_pc;
          end
        end
        S_HOLD: begin
          if (i_redirect_valid) begin
            r_pc       <= i_redirect_pc;           // buffered instruction dropped
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end else if (!w_stall) begin
            r_pc       <= w_pc4;
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // IF/ID register: flush beats everything, then IFIDWrite hold, then load/bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ifid_pc    <= '0;
      o_ifid_pc4   <= '0;
      o_ifid_instr <= '0;
      o_ifid_valid <= 1'b0;
    end else if (i_ifid_flush) begin
      o_ifid_instr <= '0;
      o_ifid_valid <= 1'b0;
    end else if (i_ifid_write) begin
      if (w_load) begin
        o_ifid_pc    <= r_pc;
        o_ifid_pc4   <= w_pc4;
        o_ifid_instr <= w_load_instr;
        o_ifid_valid <= 1'b1;
      end else begin
        o_ifid_instr <= '0;
        o_ifid_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_fetch_cnt <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (w_load && i_ifid_write && !i_ifid_flush) o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'd1;
      if (w_stall || o_fetch_busy)                 o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: PC register, instruction-memory request handshake, skid buffer and IF/ID pipeline register.
- Consumes the PC-write and IF/ID-write enables from the load-use hazard unit, plus branch/jump redirects.
- Produces the IF/ID register (pc, pc+4, instruction, valid) read by decode and by the hazard unit's Rs/Rt compare.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_write  in  1  hazard unit PCWrite; 0 = stall
- ifid_write  in  1  hazard unit IFIDWrite; 0 = stall
- ifid_flush  in  1  clear IF/ID to bubble
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  ADDR_W  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ready  in  1  rdata valid for imem_addr this cycle
- imem_rdata  in  DATA_W  fetched instruction
- ifid_pc  out  ADDR_W  PC of instruction in IF/ID
- ifid_pc4  out  ADDR_W  ifid_pc + 4
- ifid_instr  out  DATA_W  instruction; 0 (NOP) when bubble
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  high in DRAIN, or in FETCH with imem_req=1 and imem_ready=0

Behaviour:
- Reset (asynchronous, immediate): pc=RESET_PC, state=BOOT, imem_req=0, imem_addr=RESET_PC, all ifid_* = 0, skid buffer empty, redir_buf=0.
- stall = !pc_write || !ifid_write. Both inputs are normally equal; either low stalls.
- imem_addr = pc in every state. Handshake rule: while imem_req=1 and imem_ready=0, imem_addr must not change.
- Throughput is 1 instruction/cycle with imem_ready tied high. rdata is written to IF/ID on the edge ending the ready cycle.
- PC arithmetic: pc+4 modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0.
- Priority at each edge: redirect > stall > normal advance.

State machine:
- BOOT: imem_req=0 for one cycle, then -> FETCH.
- FETCH: imem_req=1. Behaviour on each edge:
  - imem_ready=1, redirect_valid=1: discard rdata; pc <= redirect_pc; stay in FETCH.
  - imem_ready=1, stall=1: rdata -> skid buffer; pc unchanged; -> HOLD.
  - imem_ready=1, otherwise: IF/ID <= {pc, pc+4, rdata, valid=1}; pc <= pc+4.
  - imem_ready=0, redirect_valid=1: redir_buf <= redirect_pc; -> DRAIN.
  - imem_ready=0, otherwise: hold.
- DRAIN: imem_req=1, address unchanged. A new redirect_valid overwrites redir_buf. On imem_ready: discard rdata; pc <= redir_buf (or redirect_pc if redirect_valid that same cycle); -> FETCH.
- HOLD: imem_req=0. Behaviour on each edge:
  - redirect_valid: drop buffer; pc <= redirect_pc; -> FETCH.
  - !stall: IF/ID <= {pc, pc+4, buffer, 1}; pc <= pc+4; -> FETCH.
  - otherwise: stay in HOLD.

IF/ID register:
- ifid_flush=1: ifid_valid <= 0, ifid_instr <= 0, ifid_pc/ifid_pc4 hold. This overrides any load in the same cycle, including a load during redirect or stall.
- ifid_write=0 and no flush: all ifid_* hold.
- No new instruction and no flush: valid <= 0 (bubble), instr <= 0.

Reset mid-operation: an outstanding request is abandoned, imem_req drops asynchronously, and fetch restarts at RESET_PC via BOOT.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each edge that loads IF/ID with valid=1.
  - perf_stall_cnt increments on each edge where stall=1 or fetch_busy=1.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ready=1, rdata=addr: after BOOT, IF/ID shows pc 0x0, 0x4, 0x8 on consecutive cycles; ifid_pc4=0x4, 0x8, 0xC; valid=1.
- At pc=0x8 drive pc_write=ifid_write=0 for 3 cycles: IF/ID holds pc 0x4. imem_req=0 during HOLD. On release, IF/ID=0x8 with buffered rdata; next 0xC; no instruction lost or duplicated.
- imem_ready=0 at pc=0x10, redirect_valid=1 to 0x100 for one cycle, ready after 2 cycles:
  - imem_addr stays 0x10 until ready.
  - The 0x10 rdata is never loaded into IF/ID.
  - Next IF/ID pc=0x100.
- ifid_flush=1 together with redirect to 0x40 while fetching 0x20: IF/ID valid=0, instr=0; next valid entry pc=0x40.
- RESET_PC=0xFFFFFFF8: IF/ID pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
- Assert rst_n=0 during DRAIN: imem_req=0 and ifid_valid=0 immediately without waiting for a clock edge. With IF_PERF_CNT_EN, after 10 fetches and 3 stall cycles: counters read 10 and 3; after reset both read 0.
